// File: rtl/tlc_pkg.sv
// Encodings shared by the traffic light controller and its country-road front end.
package tlc_pkg;

   // Light encoding used on the controller's light outputs.
   typedef enum logic [1:0] {
      RED    = 2'd0,
      YELLOW = 2'd1,
      GREEN  = 2'd2
   } light_t;

   // Detector debounce states.
   typedef enum logic [1:0] {
      ABSENT   = 2'd0,
      RISE_CHK = 2'd1,
      PRESENT  = 2'd2,
      FALL_CHK = 2'd3
   } deb_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Synchronizes the raw loop detector and debounces it, emitting one arrival
// pulse per accepted rising level.
module sensor_debounce
   import tlc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic clear_n,
   input  logic raw_det_i,
   output logic arrival_o
);

   localparam int            DW    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q;
   logic          s2_q;
   deb_state_t    state_q, state_d;
   logic [DW-1:0] dcnt_q, dcnt_d;

   // Two-flop synchronizer for the detector, which is asynchronous to clk.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= raw_det_i;
         s2_q <= s1_q;
      end
   end

   // Debounce state and stable-sample counter registers.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= ABSENT;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
      end
   end

   // A level change is accepted only after DEBOUNCE_CYCLES identical samples.
   always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      arrival_o = 1'b0;
      case (state_q)
         ABSENT: begin
            if (s2_q) begin
               state_d = RISE_CHK;
               dcnt_d  = DW'(1);
            end
         end
         RISE_CHK: begin
            if (!s2_q) begin
               state_d = ABSENT;
            end else if (dcnt_q == DLAST) begin
               state_d   = PRESENT;
               arrival_o = 1'b1;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         PRESENT: begin
            if (!s2_q) begin
               state_d = FALL_CHK;
               dcnt_d  = DW'(1);
            end
         end
         FALL_CHK: begin
            if (s2_q) begin
               state_d = PRESENT;
            end else if (dcnt_q == DLAST) begin
               state_d = ABSENT;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         default: state_d = ABSENT;
      endcase
   end

endmodule

// File: rtl/country_sensor_qualifier.sv
// Country-road front end: counts debounced vehicle arrivals, estimates departures
// from green time, and tells the controller whether anyone is waiting.
module country_sensor_qualifier
   import tlc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PASS_CYCLES     = 10,
   parameter int CNT_W           = 4
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             raw_det,
   input  logic [1:0]       cntry,
   output logic             X,
   output logic [CNT_W-1:0] queue_cnt,
   output logic             overflow
);

   localparam int               PW    = $clog2(PASS_CYCLES);
   localparam logic [PW-1:0]    PLAST = PW'(PASS_CYCLES - 1);
   localparam logic [CNT_W-1:0] CMAX  = '1;

   logic             arrival;
   logic             departure;
   logic             green;
   logic [PW-1:0]    ptmr_q, ptmr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   sensor_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .clear_n   (clear_n),
      .raw_det_i (raw_det),
      .arrival_o (arrival)
   );

   // Any light code other than GREEN, including the illegal 3, counts as not green.
   assign green     = (cntry == GREEN);
   assign departure = green && (cnt_q != '0) && (ptmr_q == PLAST);

   // Pass timer: runs only while vehicles wait on green; partial counts are dropped.
   always_comb begin
      ptmr_d = ptmr_q + PW'(1);
      if (!green || (cnt_q == '0) || (ptmr_q == PLAST)) begin
         ptmr_d = '0;
      end
   end

   // Queue update: coincident arrival and departure cancel and never flag overflow.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (arrival && !departure) begin
         if (cnt_q == CMAX) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (departure && !arrival) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Timer, queue and sticky overflow registers.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         ptmr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         ptmr_q <= ptmr_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
      end
   end

   assign X         = (cnt_q != '0);
   assign queue_cnt = cnt_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_country_sensor_qualifier.sv
// Bench for country_sensor_qualifier: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural queue model.
module tb_country_sensor_qualifier;
   import tlc_pkg::*;

   localparam int DEB  = 4;
   localparam int PASS = 10;
   localparam int CW   = 4;
   localparam int QMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          clear_n = 1'b0;
   logic          raw_det = 1'b0;
   logic [1:0]    cntry = 2'd0;
   logic          X;
   logic [CW-1:0] queue_cnt;
   logic          overflow;

   int n_chk = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   country_sensor_qualifier #(
      .DEBOUNCE_CYCLES (DEB),
      .PASS_CYCLES     (PASS),
      .CNT_W           (CW)
   ) dut (
      .clk       (clk),
      .clear_n   (clear_n),
      .raw_det   (raw_det),
      .cntry     (cntry),
      .X         (X),
      .queue_cnt (queue_cnt),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The detector value seen by the debouncer is raw_det delayed by two edges.
   // A level change is accepted once the last DEB seen samples all differ from
   // the accepted level. Departures happen every PASS-th consecutive edge of
   // "green with vehicles waiting".
   bit m_d0, m_d1;
   bit m_win[DEB];
   bit m_level;
   int m_run;
   int m_q;
   bit m_ovf;

   task automatic model_reset();
      m_d0 = 1'b0;
      m_d1 = 1'b0;
      for (int i = 0; i < DEB; i++) m_win[i] = 1'b0;
      m_level = 1'b0;
      m_run = 0;
      m_q = 0;
      m_ovf = 1'b0;
   endtask

   task automatic model_step();
      bit smp;
      bit all_ne;
      bit arr;
      bit dep;
      smp  = m_d1;
      m_d1 = m_d0;
      m_d0 = raw_det;
      for (int i = DEB - 1; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = smp;
      all_ne = 1'b1;
      for (int j = 0; j < DEB; j++) if (m_win[j] == m_level) all_ne = 1'b0;
      arr = 1'b0;
      if (all_ne) begin
         m_level = !m_level;
         arr = m_level;
      end
      dep = 1'b0;
      if (cntry == 2'd2 && m_q != 0) begin
         m_run++;
         dep = (m_run % PASS == 0);
      end else begin
         m_run = 0;
      end
      if (arr && !dep) begin
         if (m_q == QMAX) m_ovf = 1'b1;
         else m_q++;
      end else if (dep && !arr) begin
         m_q--;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge clear_n);
         if (!clear_n) model_reset();
         else model_step();
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("queue_cnt", int'(queue_cnt), m_q);
         chk("X", int'(X), int'(m_q != 0));
         chk("overflow", int'(overflow), int'(m_ovf));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic arrive();
      raw_det = 1'b1;
      repeat (8) @(negedge clk);
      raw_det = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic arrive_short();
      raw_det = 1'b1;
      repeat (6) @(negedge clk);
      raw_det = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      int raw_hold;
      int c_hold;
      raw_hold = 0;
      c_hold = 0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_queue", int'(queue_cnt), 0);
      chk("rst_X", int'(X), 0);
      chk("rst_ovf", int'(overflow), 0);
      clear_n = 1'b1;
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);

      // Basic arrival: increment lands on edge DEB+2
      raw_det = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (k == 5) chk("arr_edge5", int'(queue_cnt), 0);
         if (k >= 6) begin
            chk("arr_q", int'(queue_cnt), 1);
            chk("arr_X", int'(X), 1);
         end
      end
      @(negedge clk);
      raw_det = 1'b0;
      repeat (10) @(negedge clk);

      // Glitch shorter than DEB edges
      raw_det = 1'b1;
      repeat (3) @(negedge clk);
      raw_det = 1'b0;
      repeat (10) @(negedge clk);
      chk("glitch_q", int'(queue_cnt), 1);

      // One-cycle dropout while present
      raw_det = 1'b1;
      repeat (8) @(negedge clk);
      raw_det = 1'b0;
      @(negedge clk);
      raw_det = 1'b1;
      repeat (6) @(negedge clk);
      raw_det = 1'b0;
      repeat (8) @(negedge clk);
      chk("dropout_q", int'(queue_cnt), 2);

      // Discharge three vehicles on continuous green
      arrive();
      chk("pre_dis_q", int'(queue_cnt), 3);
      cntry = GREEN;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (k == 9)  chk("dis_e9", int'(queue_cnt), 3);
         if (k == 10) chk("dis_e10", int'(queue_cnt), 2);
         if (k == 19) chk("dis_e19", int'(queue_cnt), 2);
         if (k == 20) chk("dis_e20", int'(queue_cnt), 1);
         if (k == 29) chk("dis_e29", int'(queue_cnt), 1);
         if (k == 30) begin
            chk("dis_e30", int'(queue_cnt), 0);
            chk("dis_X30", int'(X), 0);
         end
      end
      @(negedge clk);
      cntry = RED;

      // Green interrupted at green edge 15
      arrive();
      arrive();
      arrive();
      cntry = GREEN;
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk);
         #1;
         if (k == 10) chk("part_e10", int'(queue_cnt), 2);
      end
      @(negedge clk);
      cntry = YELLOW;
      repeat (20) @(negedge clk);
      chk("yellow_hold", int'(queue_cnt), 2);
      cntry = RED;
      @(negedge clk);

      // Arrival coinciding with a departure
      cntry = GREEN;
      repeat (4) @(negedge clk);
      raw_det = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("simul_pre", int'(queue_cnt), 2);
      @(posedge clk);
      #1;
      chk("simul_q", int'(queue_cnt), 2);
      @(negedge clk);
      cntry = RED;
      repeat (3) @(negedge clk);
      raw_det = 1'b0;
      repeat (8) @(negedge clk);

      // Saturation and sticky overflow
      repeat (16) arrive_short();
      chk("sat_q", int'(queue_cnt), 15);
      chk("sat_ovf", int'(overflow), 1);
      cntry = GREEN;
      repeat (15 * PASS + 5) @(negedge clk);
      chk("drain_q", int'(queue_cnt), 0);
      chk("drain_X", int'(X), 0);
      chk("drain_ovf", int'(overflow), 1);
      cntry = RED;

      // Asynchronous reset between edges
      repeat (5) arrive();
      chk("pre_rst_q", int'(queue_cnt), 5);
      @(posedge clk);
      #3;
      clear_n = 1'b0;
      #1;
      chk("arst_q", int'(queue_cnt), 0);
      chk("arst_X", int'(X), 0);
      chk("arst_ovf", int'(overflow), 0);
      repeat (2) @(negedge clk);
      clear_n = 1'b1;

      // Randomized traffic with one asynchronous reset pulse
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (raw_hold == 0) begin
            raw_det  = 1'($urandom_range(0, 1));
            raw_hold = $urandom_range(1, 12);
         end else begin
            raw_hold--;
         end
         if (c_hold == 0) begin
            cntry  = 2'($urandom_range(0, 3));
            c_hold = $urandom_range(1, 60);
         end else begin
            c_hold--;
         end
         if (i == 2000) begin
            #2 clear_n = 1'b0;
            #4 clear_n = 1'b1;
         end
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/country_sensor_qualifier.md
# country_sensor_qualifier

Upstream stage of the traffic light controller. Conditions the raw country-road loop-detector signal and maintains a saturating count of vehicles waiting. Drives the controller's `X` input (`X` = 1 while any vehicle is queued) and consumes the controller's `cntry` light output to estimate when queued vehicles have cleared.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4 — consecutive stable synchronized samples required to accept a detector level change (≥2).
- `PASS_CYCLES`, 10 — country-green cycles per discharged vehicle (≥2).
- `CNT_W`, 4 — queue counter width; saturates at 2^CNT_W−1.

Ports:
- `clk` in 1 — single clock, rising edge.
- `clear_n` in 1 — asynchronous, active-low reset.
- `raw_det` in 1 — loop detector, asynchronous to `clk`, 1 = vehicle over loop.
- `cntry` in 2 — country light from the controller; RED=0, YELLOW=1, GREEN=2.
- `X` out 1 — vehicle waiting; drives the controller's `X` input.
- `queue_cnt` out CNT_W — vehicles currently queued.
- `overflow` out 1 — sticky; an arrival occurred while the counter was saturated.

## Operation
- Synchronizer: two flops, `raw_det` → `s1` → `s2`. Reset value 0.
- Debounce FSM on `s2`, with stable counter `dcnt`:
  - ABSENT: `s2`=1 → RISE_CHK, `dcnt`=1.
  - RISE_CHK: `s2`=1 and `dcnt`=DEBOUNCE_CYCLES−1 → PRESENT and assert a one-cycle arrival pulse. `s2`=1 otherwise → `dcnt`++. `s2`=0 → ABSENT.
  - PRESENT: `s2`=0 → FALL_CHK, `dcnt`=1.
  - FALL_CHK: `s2`=0 and `dcnt`=DEBOUNCE_CYCLES−1 → ABSENT. `s2`=0 otherwise → `dcnt`++. `s2`=1 → PRESENT.
  - Unused encodings → ABSENT.
- Pass timer `ptmr`:
  - Cleared whenever `cntry`≠GREEN or `queue_cnt`=0.
  - Otherwise increments each cycle. On reaching PASS_CYCLES−1 it wraps to 0 and asserts a one-cycle departure pulse.
- Queue counter, next-state rules:
  - arrival only → +1, saturating at max. Arrival while already at max sets `overflow`.
  - departure only → −1. Never underflows, because departure requires `queue_cnt`≠0.
  - arrival and departure on the same edge → unchanged. `overflow` is not set.
- `X` = (`queue_cnt`≠0). Decoded from the counter register, with no added latency.
- `overflow` is cleared only by `clear_n`.
- `cntry` values other than GREEN, including the illegal value 3, are treated as not-green.

## Timing
- Reset: `clear_n` low asynchronously forces the following, regardless of `clk`:
  - `s1`, `s2` → 0; FSM → ABSENT; `dcnt`, `ptmr` → 0.
  - `queue_cnt` → 0, `X` → 0, `overflow` → 0.
- Reset mid-operation discards all queued vehicles and in-progress debounce. After release, a detector already high counts as a fresh arrival.
- Release of `clear_n` is synchronized externally; the block itself adds no deassertion logic.
- Arrival latency:
  - Edge 1 is the first edge sampling `raw_det`=1.
  - With the level held, `queue_cnt` increments and `X` rises at edge DEBOUNCE_CYCLES+2 (edge 6 with defaults).
- Glitch rejection: a `raw_det` pulse held for fewer than DEBOUNCE_CYCLES edges never produces an arrival.
- Departure: with `cntry`=GREEN continuously from edge 1 and `queue_cnt`=N>0:
  - The first decrement occurs at edge PASS_CYCLES.
  - Subsequent decrements follow every PASS_CYCLES edges.
  - `X` falls at edge N·PASS_CYCLES.
- Leaving GREEN mid-interval discards the partial `ptmr` count.

## Structure
- Shared package `tlc_pkg` holds:
  - Light encoding RED/YELLOW/GREEN, shared with the controller.
  - Debounce state encoding ABSENT/RISE_CHK/PRESENT/FALL_CHK.
- One sub-module, `sensor_debounce`:
  - Contains the synchronizer, the FSM and `dcnt`.
  - Parameterized by DEBOUNCE_CYCLES.
  - Outputs the arrival pulse.
- The top level holds `ptmr`, `queue_cnt` and `overflow`.

## Test plan
- Reset/basic arrival: release `clear_n`, then drive `raw_det`=1 for 8 cycles → `queue_cnt`=1 and `X`=1 at edge 6; no further increment while `raw_det` is held.
- Glitch: `raw_det`=1 for 3 cycles, then 0 → `queue_cnt` stays 0 and `X` stays 0; a 1-cycle dropout inside PRESENT produces no second arrival.
- Discharge: 3 debounced arrivals, then `cntry`=GREEN held → `queue_cnt` 3→2→1→0 at green edges 10/20/30; `X` falls at edge 30; GREEN→YELLOW at green edge 15 leaves `queue_cnt`=2.
- Simultaneous events: arrival pulse aligned with a departure edge → `queue_cnt` unchanged.
- Saturation: 16 arrivals with CNT_W=4 → `queue_cnt`=15 and `overflow`=1; `overflow` stays 1 after discharge to 0.
- Async reset: assert `clear_n` between clock edges with `queue_cnt`=5 → all outputs 0 immediately, before the next edge.
